// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl
//   Turns single-cycle peripheral event pulses into level-sensitive interrupt
//   requests for the RISC-V core. Each request is held until the core acks
//   that ID. Further events on a line are counted. They re-assert the line
//   after a programmable low gap. Illegal acks and dropped events are
//   reported through sticky flags.
//
// Ports
//   clk        core clock
//   rst_n      asynchronous active-low reset
//   evt_i      per-line event pulses (one pulse = one event)
//   irq_ack_i  core acknowledge pulse
//   irq_id_i   ID being acknowledged (meaningful only with irq_ack_i)
//   clr_i      clears ovf_o and ack_err_o (a same-cycle set wins)
//   irq_o      registered request levels to the core
//   ovf_o      sticky per-line "event dropped at counter saturation"
//   ack_err_o  sticky "ack for an ID that is not currently requested"
//
// Handshake: irq_o[i] is a level. It stays high until a cycle with
// irq_ack_i = 1 and irq_id_i == i. That cycle completes the transfer, and
// the line goes low on the next cycle. An ack for a line that is not high
// changes nothing except ack_err_o.
module irq_source_ctrl #(
    parameter logic [31:0] VALID_MASK = 32'h0000_0888,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned REARM_GAP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] evt_i,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_i,
    input  logic        clr_i,
    output logic [31:0] irq_o,
    output logic [31:0] ovf_o,
    output logic        ack_err_o
);

    localparam int unsigned GAP_W = (REARM_GAP < 1) ? 1 : $clog2(REARM_GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_GAP    = 2'd2
    } state_e;

    // Per-line "currently requesting" view. Unimplemented lines read as 0,
    // so an ack to them is flagged by the same test as an ack to a low line.
    logic [31:0] asserted_w;
    logic        ack_err_q;
    logic        ack_err_set;

    assign ack_err_set = irq_ack_i && !asserted_w[irq_id_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= ack_err_set | (ack_err_q & ~clr_i);
        end
    end

    assign ack_err_o = ack_err_q;

    for (genvar i = 0; i < 32; i++) begin : g_line
        if (VALID_MASK[i]) begin : g_impl
            state_e               state_q;
            logic                 irq_q;
            logic                 ovf_q;
            logic [CNT_W-1:0]     cnt_q;
            logic [CNT_W-1:0]     cnt_d;
            logic [GAP_W-1:0]     gap_q;
            logic                 ack_hit;
            logic                 last_gap;
            logic                 consume;
            logic                 enq;
            logic                 ovf_set;

            assign ack_hit  = irq_ack_i && (irq_id_i == 5'(i));
            assign last_gap = (state_q == S_GAP) && (gap_q == GAP_W'(1));
            // A queued event, or one arriving right now, is turned into the
            // next assertion at the end of the gap.
            assign consume  = last_gap && ((cnt_q != '0) || evt_i[i]);
            // In IDLE the event is used by the assertion itself, so it is not queued.
            assign enq      = evt_i[i] && (state_q != S_IDLE);

            // Queue counter. An enqueue and a consume in the same cycle cancel.
            // That is why a saturated counter drops an event only when there
            // is no consume in that cycle.
            always_comb begin
                cnt_d   = cnt_q;
                ovf_set = 1'b0;
                if (enq && !consume) begin
                    if (cnt_q == '1) begin
                        ovf_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (!enq && consume) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= S_IDLE;
                    irq_q   <= 1'b0;
                    ovf_q   <= 1'b0;
                    cnt_q   <= '0;
                    gap_q   <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_set | (ovf_q & ~clr_i);
                    case (state_q)
                        S_IDLE: begin
                            if (evt_i[i]) begin
                                state_q <= S_ASSERT;
                                irq_q   <= 1'b1;
                            end
                        end
                        S_ASSERT: begin
                            if (ack_hit) begin
                                state_q <= S_GAP;
                                irq_q   <= 1'b0;
                                gap_q   <= GAP_W'(REARM_GAP);
                            end
                        end
                        S_GAP: begin
                            gap_q <= gap_q - GAP_W'(1);
                            if (last_gap) begin
                                if (consume) begin
                                    state_q <= S_ASSERT;
                                    irq_q   <= 1'b1;
                                end else begin
                                    state_q <= S_IDLE;
                                end
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                            irq_q   <= 1'b0;
                        end
                    endcase
                end
            end

            assign irq_o[i]      = irq_q;
            assign ovf_o[i]      = ovf_q;
            assign asserted_w[i] = irq_q;
        end else begin : g_tied
            logic unused_evt;
            assign unused_evt    = evt_i[i];
            assign irq_o[i]      = 1'b0;
            assign ovf_o[i]      = 1'b0;
            assign asserted_w[i] = 1'b0;
        end
    end

endmodule
